// File: rtl/hyper_axi_bist_pkg.sv
// Shared types, LFSR constants and step function for the HyperBus AXI BIST master.
package hyper_axi_bist_pkg;

    localparam int unsigned PkgAddrWidth = 32;
    localparam int unsigned PkgDataWidth = 64;
    localparam int unsigned PkgIdWidth   = 6;

    localparam logic [31:0] LfsrPoly        = 32'h8020_0003;
    localparam logic [31:0] LfsrDefaultSeed = 32'h1;

    typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE} state_e;

    typedef struct packed {
        logic [PkgIdWidth-1:0]     aw_id;
        logic [PkgAddrWidth-1:0]   aw_addr;
        logic [7:0]                aw_len;
        logic [2:0]                aw_size;
        logic [1:0]                aw_burst;
        logic                      aw_valid;
        logic [PkgDataWidth-1:0]   w_data;
        logic [PkgDataWidth/8-1:0] w_strb;
        logic                      w_last;
        logic                      w_valid;
        logic                      b_ready;
        logic [PkgIdWidth-1:0]     ar_id;
        logic [PkgAddrWidth-1:0]   ar_addr;
        logic [7:0]                ar_len;
        logic [2:0]                ar_size;
        logic [1:0]                ar_burst;
        logic                      ar_valid;
        logic                      r_ready;
    } bist_axi_req_t;

    typedef struct packed {
        logic                    aw_ready;
        logic                    w_ready;
        logic [PkgIdWidth-1:0]   b_id;
        logic [1:0]              b_resp;
        logic                    b_valid;
        logic                    ar_ready;
        logic [PkgIdWidth-1:0]   r_id;
        logic [PkgDataWidth-1:0] r_data;
        logic [1:0]              r_resp;
        logic                    r_last;
        logic                    r_valid;
    } bist_axi_rsp_t;

    // Galois form, right shift: feedback taps applied when bit 0 falls out.
    function automatic logic [31:0] next_lfsr(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LfsrPoly : 32'h0);
    endfunction

endpackage

// File: rtl/hyper_axi_bist_lfsr.sv
// 32-bit pattern LFSR: load has priority over enable; a zero seed loads the default seed.
module hyper_axi_bist_lfsr
    import hyper_axi_bist_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 32'h0) ? LfsrDefaultSeed : seed_i;
        end else if (en_i) begin
            lfsr_d = next_lfsr(lfsr_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            lfsr_q <= LfsrDefaultSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/hyper_axi_bist.sv
// AXI4 BIST master: writes an LFSR pattern over a window in INCR bursts, reads back and compares.
// One transaction outstanding, stalls on AXI handshakes; HYPER_AXI_BIST_INJECT_EN adds a one-bit error injector.
module hyper_axi_bist
    import hyper_axi_bist_pkg::*;
#(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 6,
    parameter int unsigned MaxBurstLen  = 16,
    parameter type axi_req_t = hyper_axi_bist_pkg::bist_axi_req_t,
    parameter type axi_rsp_t = hyper_axi_bist_pkg::bist_axi_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
`ifdef HYPER_AXI_BIST_INJECT_EN
    input  logic                    inject_i,
`endif
    input  logic                    start_i,
    input  logic [AxiAddrWidth-1:0] base_addr_i,
    input  logic [AxiAddrWidth-1:0] length_i,
    input  logic [31:0]             seed_i,
    output axi_req_t                axi_req_o,
    input  axi_rsp_t                axi_rsp_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [15:0]             err_count_o,
    output logic [AxiAddrWidth-1:0] first_err_addr_o
);

    localparam int unsigned BeatShift = $clog2(AxiDataWidth / 8);
    localparam int unsigned AlignBits = $clog2(MaxBurstLen * AxiDataWidth / 8);
    localparam logic [AxiAddrWidth-1:0] MaxBeats = AxiAddrWidth'(MaxBurstLen);

    state_e                  state_q, state_d;
    logic [AxiAddrWidth-1:0] base_q, base_d, addr_q, addr_d;
    logic [AxiAddrWidth-1:0] total_q, total_d, rem_q, rem_d;
    logic [AxiAddrWidth-1:0] first_err_q, first_err_d;
    logic [31:0]             seed_q, seed_d;
    logic [7:0]              beat_q, beat_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic                    error_q, error_d;

    logic                    lfsr_load, lfsr_en;
    logic [31:0]             lfsr_seed, lfsr_state;
    logic [AxiAddrWidth-1:0] burst_beats, burst_bytes, rd_beat_addr;
    logic [7:0]              ax_len;
    logic [AxiDataWidth-1:0] exp_beat, wr_beat;
    logic [AxiIdWidth-1:0]   axi_id;
    logic                    cfg_bad, last_burst, rd_bad;
    logic                    unused_rsp;

    assign axi_id       = '0;
    assign unused_rsp   = ^{axi_rsp_i.b_id, axi_rsp_i.r_id};
    assign burst_beats  = (rem_q > MaxBeats) ? MaxBeats : rem_q;
    assign burst_bytes  = burst_beats << BeatShift;
    assign ax_len       = 8'(burst_beats - 1'b1);
    assign last_burst   = (rem_q == burst_beats);
    assign rd_beat_addr = addr_q + (AxiAddrWidth'(beat_q) << BeatShift);
    assign exp_beat     = {(AxiDataWidth / 32){lfsr_state}};
    assign rd_bad       = (axi_rsp_i.r_data != exp_beat) || (axi_rsp_i.r_resp != 2'b00);
    assign cfg_bad      = (length_i == '0) || (length_i[BeatShift-1:0] != '0)
                       || (base_addr_i[AlignBits-1:0] != '0);
    // seed_i is only live on the start cycle; the read phase replays the latched copy
    assign lfsr_seed    = (state_q == IDLE) ? seed_i : seed_q;

`ifdef HYPER_AXI_BIST_INJECT_EN
    logic armed_q, armed_d, w_hs;
    assign w_hs    = (state_q == WR_W) && axi_rsp_i.w_ready;
    assign armed_d = armed_q ? !w_hs : inject_i;
    assign wr_beat = {exp_beat[AxiDataWidth-1:1], exp_beat[0] ^ armed_q};

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) armed_q <= 1'b0;
        else       armed_q <= armed_d;
    end
`else
    assign wr_beat = exp_beat;
`endif

    hyper_axi_bist_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .en_i    (lfsr_en),
        .seed_i  (lfsr_seed),
        .state_o (lfsr_state)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        total_d     = total_q;
        rem_d       = rem_q;
        seed_d      = seed_q;
        beat_d      = beat_q;
        err_cnt_d   = err_cnt_q;
        error_d     = error_q;
        first_err_d = first_err_q;
        lfsr_load   = 1'b0;
        lfsr_en     = 1'b0;

        axi_req_o          = '0;
        axi_req_o.aw_id    = axi_id;
        axi_req_o.aw_addr  = addr_q;
        axi_req_o.aw_len   = ax_len;
        axi_req_o.aw_size  = 3'(BeatShift);
        axi_req_o.aw_burst = 2'b01;
        axi_req_o.w_data   = wr_beat;
        axi_req_o.w_strb   = '1;
        axi_req_o.w_last   = (beat_q == ax_len);
        axi_req_o.ar_id    = axi_id;
        axi_req_o.ar_addr  = addr_q;
        axi_req_o.ar_len   = ax_len;
        axi_req_o.ar_size  = 3'(BeatShift);
        axi_req_o.ar_burst = 2'b01;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    error_d     = cfg_bad;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    base_d      = base_addr_i;
                    addr_d      = base_addr_i;
                    total_d     = length_i >> BeatShift;
                    rem_d       = length_i >> BeatShift;
                    seed_d      = seed_i;
                    lfsr_load   = !cfg_bad;
                    state_d     = cfg_bad ? DONE : WR_AW;
                end
            end
            WR_AW: begin
                axi_req_o.aw_valid = 1'b1;
                beat_d = '0;
                if (axi_rsp_i.aw_ready) state_d = WR_W;
            end
            WR_W: begin
                axi_req_o.w_valid = 1'b1;
                if (axi_rsp_i.w_ready) begin
                    lfsr_en = 1'b1;
                    beat_d  = beat_q + 8'd1;
                    if (beat_q == ax_len) state_d = WR_B;
                end
            end
            WR_B: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_rsp_i.b_valid) begin
                    if (axi_rsp_i.b_resp != 2'b00) error_d = 1'b1;
                    if (last_burst) begin
                        addr_d    = base_q;
                        rem_d     = total_q;
                        lfsr_load = 1'b1;
                        state_d   = RD_AR;
                    end else begin
                        addr_d  = addr_q + burst_bytes;
                        rem_d   = rem_q - burst_beats;
                        state_d = WR_AW;
                    end
                end
            end
            RD_AR: begin
                axi_req_o.ar_valid = 1'b1;
                beat_d = '0;
                if (axi_rsp_i.ar_ready) state_d = RD_R;
            end
            RD_R: begin
                axi_req_o.r_ready = 1'b1;
                if (axi_rsp_i.r_valid) begin
                    lfsr_en = 1'b1;
                    beat_d  = beat_q + 8'd1;
                    if (rd_bad) begin
                        error_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        if (err_cnt_q == '0)       first_err_d = rd_beat_addr;
                    end
                    if (axi_rsp_i.r_last) begin
                        addr_d  = addr_q + burst_bytes;
                        rem_d   = rem_q - burst_beats;
                        state_d = last_burst ? DONE : RD_AR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            total_q     <= '0;
            rem_q       <= '0;
            seed_q      <= '0;
            beat_q      <= '0;
            err_cnt_q   <= '0;
            error_q     <= 1'b0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            rem_q       <= rem_d;
            seed_q      <= seed_d;
            beat_q      <= beat_d;
            err_cnt_q   <= err_cnt_d;
            error_q     <= error_d;
            first_err_q <= first_err_d;
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign error_o          = error_q;
    assign err_count_o      = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule

// File: doc/hyper_axi_bist.md
Name: hyper_axi_bist

Overview:
Synthesizable AXI4 built-in self-test master for the HyperBus memory controller.
- Writes a seeded pseudo-random pattern over a programmable address window in INCR bursts.
- Reads the window back and compares every beat against the regenerated pattern.
- Reports pass/fail, error count and first failing address.
- Sits in front of the controller's AXI slave port; an external AXI mux selects between BIST and system traffic.

Parameters:
- AxiAddrWidth, 32, AXI address width.
- AxiDataWidth, 64, AXI data width; multiple of 32.
- AxiIdWidth, 6, AXI ID width; BIST always drives ID 0.
- MaxBurstLen, 16, maximum beats per burst; power of two, burst bytes ≤ 4096.
- axi_req_t, logic, AXI request struct type.
- axi_rsp_t, logic, AXI response struct type.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse, accepted only in IDLE
- base_addr_i  in  AxiAddrWidth  window start; aligned to MaxBurstLen*AxiDataWidth/8
- length_i  in  AxiAddrWidth  window size in bytes
- seed_i  in  32  LFSR seed; 0 is replaced by 32'h1
- axi_req_o  out  axi_req_t  AXI master request
- axi_rsp_i  in  axi_rsp_t  AXI master response
- busy_o  out  1  test running
- done_o  out  1  one-cycle pulse at completion
- error_o  out  1  sticky: any mismatch, SLVERR/DECERR, or config error; cleared on start
- err_count_o  out  16  mismatching beats, saturating at 16'hFFFF
- first_err_addr_o  out  AxiAddrWidth  address of first failing beat

Behaviour:
- Reset (rst_n=1): FSM to IDLE; all valid/ready outputs 0; busy_o, done_o, error_o 0; err_count_o 0; first_err_addr_o 0; LFSR = 32'h1.
  - Reset mid-burst abandons the transaction; the integrator must reset the slave too.
- Config check on start: length_i==0, length_i not a multiple of the beat size, or base_addr_i misaligned → error_o=1, done_o pulses next cycle, no AXI traffic.
- FSM:
  - IDLE→WR_AW on valid start.
  - WR_AW: assert aw_valid until aw_ready.
  - WR_AW→WR_W: stream beats, w_valid held continuously, w_last on final beat.
  - WR_W→WR_B: b_ready=1; on b_valid, next burst, or RD_AR when the window is exhausted.
  - RD_AR: LFSR reloaded with seed on entry; assert ar_valid until ar_ready.
  - RD_R: r_ready=1 and compare each beat; on r_last, next burst or DONE.
  - DONE: done_o pulse, then IDLE.
  - One outstanding transaction at a time; AW is never issued before the previous B.
- Burst: INCR; size = log2(AxiDataWidth/8); len = min(MaxBurstLen, remaining beats) − 1. The last burst may be shorter.
- Data: beat = 32-bit LFSR value replicated AxiDataWidth/32 times; w_strb all ones.
  - Galois LFSR, polynomial mask 32'h8020_0003, right shift.
  - Advances once per accepted W beat and once per accepted R beat.
- Compare on an accepted R beat: a mismatch or r_resp≠OKAY increments err_count (saturating) and sets error_o. first_err_addr_o latches only on the first error of a run.
- b_resp≠OKAY sets error_o; the count is unchanged.
- An AXI handshake in the same cycle as start_i is impossible: IDLE drives no valids.
- start_i while busy_o is ignored.
- Address counter wraps modulo 2^AxiAddrWidth; base+length overflow is not checked.

Optional Feature:
HYPER_AXI_BIST_INJECT_EN
- Defined: adds port inject_i (in, 1). A pulse arms a flag; the next accepted W beat has bit 0 inverted, then the flag clears.
  - Arming while already armed has no effect.
  - The read phase must then report exactly one mismatch.
- Undefined: no port, no flag, data is never modified.

Decomposition:
- Package hyper_axi_bist_pkg:
  - FSM state enum (IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE).
  - LfsrPoly = 32'h8020_0003, LfsrDefaultSeed = 32'h1.
  - Function next_lfsr().
- Sub-module hyper_axi_bist_lfsr: load, enable, state output. Single instance, reloaded between phases.

Test Plan:
- base 32'h8000_0000, length 32'h400, seed 32'hCAFE_F00D, MaxBurstLen 16, 64-bit data → 8 AW + 8 AR bursts with len 15; done_o pulses; error_o=0; err_count_o=0.
- length 32'h48 (9 beats) → bursts len 15? no: one burst len 8 (9 beats) each phase; last-beat w_last correct; pass.
- Slave memory model flips bit 5 at 32'h8000_0108 → err_count_o=1; first_err_addr_o=32'h8000_0108; error_o=1.
- base 32'h8000_0004 → error_o=1 and done_o within 2 cycles; no aw_valid/ar_valid observed.
- Slave returns SLVERR on the third B → error_o=1, err_count_o=0, test still completes.
- With HYPER_AXI_BIST_INJECT_EN, inject_i pulsed before start, length 32'h100 → err_count_o=1, first_err_addr_o=base. Then assert rst_n mid-RD_R → all outputs return to reset values next cycle.
